// File: rtl/sample_scheduler_if.sv
// Sample-path bus between the scheduler and its XADC, FIR and DAC neighbours.
//
// Handshake rules, in one place:
//   fir_tvalid/fir_tready: AXI-Stream. A beat transfers on the rising edge where
//   both are high. Once fir_tvalid is raised, fir_tdata holds until that edge.
//   The only other way fir_tvalid drops is the scheduler's watchdog abort.
//   fir_out_tvalid: no backpressure. fir_out_tdata is valid only while it is high.
//   adc_convst, adc_eoc and dac_set are single-cycle pulses.
//   dac_busy is a level, high while the DAC serializer is shifting.
interface sample_scheduler_if;
  logic        adc_convst;
  logic        adc_eoc;
  logic [11:0] adc_data;
  logic        fir_tvalid;
  logic        fir_tready;
  logic [15:0] fir_tdata;
  logic        fir_out_tvalid;
  logic [31:0] fir_out_tdata;
  logic [11:0] dac_value;
  logic        dac_set;
  logic        dac_busy;

  // The scheduler side.
  modport master (
    output adc_convst, fir_tvalid, fir_tdata, dac_value, dac_set,
    input  adc_eoc, adc_data, fir_tready, fir_out_tvalid, fir_out_tdata, dac_busy
  );

  // The peripheral side.
  modport slave (
    input  adc_convst, fir_tvalid, fir_tdata, dac_value, dac_set,
    output adc_eoc, adc_data, fir_tready, fir_out_tvalid, fir_out_tdata, dac_busy
  );
endinterface

// File: rtl/sample_scheduler.sv
// Sample scheduler. A programmable divider paces the sample ticks.
// Each accepted tick runs one ADC -> FIR -> DAC pass.
// Ticks that arrive mid-pass are dropped and set the sticky overrun flag.
// A watchdog aborts a pass that stalls in any wait state.
module sample_scheduler #(
  parameter int unsigned DIV_DEFAULT    = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               div_load,
  input  logic [15:0]        div_value,
  input  logic               clear_flags,
  sample_scheduler_if.master bus,
  output logic               overrun,
  output logic               timeout,
  output logic [15:0]        sample_count,
  output logic [2:0]         dbg_state
);

  localparam logic [15:0] DIV_RST = 16'(DIV_DEFAULT);
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CONV, WAIT_ADC, FIR_IN, WAIT_FIR, DAC_SET, DAC_HOLD, WAIT_DAC
  } state_t;

  state_t          state, state_n;
  logic [15:0]     cnt, div;
  logic            tick;
  logic [WD_W-1:0] wd;
  logic            in_wait;
  logic            latch_adc, latch_dac, sample_done, wd_expire;
  logic [15:0]     fir_tdata_q;
  logic [11:0]     dac_value_q;
  logic            unused_fir_bits;

  // A div_load cycle never ticks, even if the old count sat at div-1.
  assign tick    = enable && !div_load && (cnt == div - 16'd1);
  assign in_wait = state inside {WAIT_ADC, FIR_IN, WAIT_FIR, WAIT_DAC};

  // Sample divider. The counter is held at 0 while disabled.
  // Divide values below 2 are raised to 2, so a tick can never be back-to-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      div <= DIV_RST;
    end else if (div_load) begin
      cnt <= '0;
      div <= (div_value < 16'd2) ? 16'd2 : div_value;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic and datapath strobes.
  // When a wait state's exit and its watchdog limit land in the same cycle,
  // the exit wins.
  always_comb begin
    state_n     = state;
    latch_adc   = 1'b0;
    latch_dac   = 1'b0;
    sample_done = 1'b0;
    wd_expire   = 1'b0;
    case (state)
      IDLE:     if (tick) state_n = CONV;
      CONV:     state_n = WAIT_ADC;
      WAIT_ADC: if (bus.adc_eoc) begin
                  latch_adc = 1'b1;
                  state_n   = FIR_IN;
                end
      FIR_IN:   if (bus.fir_tready) state_n = WAIT_FIR;
      WAIT_FIR: if (bus.fir_out_tvalid) begin
                  latch_dac = 1'b1;
                  state_n   = DAC_SET;
                end
      DAC_SET:  state_n = DAC_HOLD;
      DAC_HOLD: state_n = WAIT_DAC;
      WAIT_DAC: if (!bus.dac_busy) begin
                  sample_done = 1'b1;
                  state_n     = IDLE;
                end
      default:  state_n = IDLE;
    endcase
    if (in_wait && (state_n == state) && (wd == WD_LAST)) begin
      wd_expire = 1'b1;
      state_n   = IDLE;
    end
  end

  // Watchdog: counts the cycles spent in the current wait state.
  // It restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst || (state_n != state)) wd <= '0;
    else if (in_wait)              wd <= wd + WD_W'(1);
  end

  // Sample datapath. The FIR input is the zero-extended ADC code.
  // The DAC code is bits [27:16] of the signed FIR result, shifted to offset binary.
  always_ff @(posedge clk) begin
    if (rst) begin
      fir_tdata_q <= '0;
      dac_value_q <= 12'h800;
    end else begin
      if (latch_adc) fir_tdata_q <= {4'b0000, bus.adc_data};
      if (latch_dac) dac_value_q <= bus.fir_out_tdata[27:16] + 12'h800;
    end
  end

  // Sticky error flags. A set condition in the same cycle beats clear_flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      overrun <= (tick && (state != IDLE)) || (overrun && !clear_flags);
      timeout <= wd_expire || (timeout && !clear_flags);
    end
  end

  // Completed-sample counter. It wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)              sample_count <= '0;
    else if (sample_done) sample_count <= sample_count + 16'd1;
  end

  assign bus.adc_convst = (state == CONV);
  assign bus.fir_tvalid = (state == FIR_IN);
  assign bus.dac_set    = (state == DAC_SET);
  assign bus.fir_tdata  = fir_tdata_q;
  assign bus.dac_value  = dac_value_q;
  assign dbg_state      = state;

  // Only fir_out_tdata[27:16] carries DAC-relevant bits.
  assign unused_fir_bits = ^{bus.fir_out_tdata[31:28], bus.fir_out_tdata[15:0]};

endmodule

// File: tb/tb_sample_scheduler.sv
// Testbench for sample_scheduler.
// Peripheral responders emulate the XADC, FIR and DAC.
// A transaction-level model predicts every output each cycle.
// Directed phases add hand-computed literal checks.
module tb_sample_scheduler;

  localparam int DIV_DEF = 10000;
  localparam int TMO     = 1023;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic        enable, div_load, clear_flags;
  logic [15:0] div_value;
  logic        overrun, timeout;
  logic [15:0] sample_count;
  logic [2:0]  dbg_state;
  int          cyc;

  sample_scheduler_if bus();

  sample_scheduler #(.DIV_DEFAULT(DIV_DEF), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .div_load(div_load),
    .div_value(div_value), .clear_flags(clear_flags), .bus(bus),
    .overrun(overrun), .timeout(timeout), .sample_count(sample_count),
    .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- peripheral responders (drive at negedge) ----------------
  int          adc_lat, fir_lat, dac_len;
  logic        tready_mode, stray;
  logic [31:0] fir_word;
  int          adc_cd, fir_cd, dac_cd;

  // The XADC answers convst with one eoc pulse adc_lat cycles later.
  // The FIR answers each accepted beat with one result fir_lat cycles later.
  // The DAC holds busy for dac_len cycles after dac_set.
  // In stray mode, random unsolicited eoc and result pulses also appear.
  always @(negedge clk) begin
    if (rst) begin
      adc_cd = 0; fir_cd = 0; dac_cd = 0;
      bus.adc_eoc = 1'b0; bus.adc_data = '0;
      bus.fir_out_tvalid = 1'b0; bus.fir_out_tdata = '0;
      bus.dac_busy = 1'b0;
    end else begin
      bus.adc_eoc        = 1'b0;
      bus.fir_out_tvalid = 1'b0;
      bus.adc_data       = 12'($urandom_range(0, 4095));
      bus.fir_out_tdata  = $urandom;
      if (adc_cd != 0) begin
        adc_cd--;
        if (adc_cd == 0) bus.adc_eoc = 1'b1;
      end
      if (bus.adc_convst) adc_cd = adc_lat;
      if (fir_cd != 0) begin
        fir_cd--;
        if (fir_cd == 0) begin
          bus.fir_out_tvalid = 1'b1;
          bus.fir_out_tdata  = fir_word;
        end
      end
      if (bus.fir_tvalid && bus.fir_tready) fir_cd = fir_lat;
      if (stray && ($urandom_range(0, 15) == 0)) bus.adc_eoc = 1'b1;
      if (stray && ($urandom_range(0, 15) == 0)) bus.fir_out_tvalid = 1'b1;
      if (dac_cd != 0) begin
        bus.dac_busy = 1'b1;
        dac_cd--;
      end else begin
        bus.dac_busy = 1'b0;
      end
      if (bus.dac_set) dac_cd = dac_len;
    end
    bus.fir_tready = tready_mode;
  end

  // ---------------- behavioural model (updates at posedge) ----------------
  // The model walks each sample's life through the steps that the outside world sees:
  // start pulse, await conversion, offer to FIR, await result,
  // write pulse, settle, await DAC.
  // Ticks come from divider arithmetic.
  localparam int P_IDLE = 0, P_START = 1, P_ADC = 2, P_OFFER = 3;
  localparam int P_RESULT = 4, P_WRITE = 5, P_SETTLE = 6, P_DACW = 7;

  int          m_phase, m_nxt, m_age, m_cnt, m_div;
  bit          m_tick, m_tmo, seen_rst;
  logic        exp_convst, exp_tvalid, exp_set, exp_ovr, exp_tmo;
  logic [15:0] exp_tdata, exp_count;
  logic [11:0] exp_dac;

  initial seen_rst = 0;

  always @(posedge clk) begin
    if (rst) begin
      seen_rst  = 1;
      m_phase   = P_IDLE; m_age = 0; m_cnt = 0; m_div = DIV_DEF;
      exp_ovr   = 1'b0; exp_tmo = 1'b0;
      exp_tdata = '0; exp_dac = 12'h800; exp_count = '0;
    end else if (seen_rst) begin
      m_tick = enable && !div_load && (m_cnt == m_div - 1);
      if (div_load) begin
        m_div = (div_value < 2) ? 2 : int'(div_value);
        m_cnt = 0;
      end else if (!enable || m_tick) m_cnt = 0;
      else m_cnt = m_cnt + 1;

      m_nxt = m_phase;
      m_tmo = 0;
      case (m_phase)
        P_IDLE:   if (m_tick) m_nxt = P_START;
        P_START:  m_nxt = P_ADC;
        P_ADC:    if (bus.adc_eoc) begin
                    exp_tdata = {4'b0000, bus.adc_data};
                    m_nxt = P_OFFER;
                  end
        P_OFFER:  if (bus.fir_tready) m_nxt = P_RESULT;
        P_RESULT: if (bus.fir_out_tvalid) begin
                    exp_dac = bus.fir_out_tdata[27:16] + 12'h800;
                    m_nxt = P_WRITE;
                  end
        P_WRITE:  m_nxt = P_SETTLE;
        P_SETTLE: m_nxt = P_DACW;
        P_DACW:   if (!bus.dac_busy) begin
                    exp_count = exp_count + 16'd1;
                    m_nxt = P_IDLE;
                  end
        default:  m_nxt = P_IDLE;
      endcase
      if ((m_nxt == m_phase) && (m_phase inside {P_ADC, P_OFFER, P_RESULT, P_DACW})) begin
        m_age++;
        if (m_age == TMO) begin
          m_tmo = 1;
          m_nxt = P_IDLE;
          m_age = 0;
        end
      end else m_age = 0;

      exp_ovr = (m_tick && (m_phase != P_IDLE)) || (exp_ovr && !clear_flags);
      exp_tmo = m_tmo || (exp_tmo && !clear_flags);
      m_phase = m_nxt;
    end
    exp_convst = (m_phase == P_START);
    exp_tvalid = (m_phase == P_OFFER);
    exp_set    = (m_phase == P_WRITE);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (seen_rst) begin
      chk("adc_convst",   bus.adc_convst, exp_convst);
      chk("fir_tvalid",   bus.fir_tvalid, exp_tvalid);
      chk("fir_tdata",    bus.fir_tdata,  exp_tdata);
      chk("dac_set",      bus.dac_set,    exp_set);
      chk("dac_value",    bus.dac_value,  exp_dac);
      chk("overrun",      overrun,        exp_ovr);
      chk("timeout",      timeout,        exp_tmo);
      chk("sample_count", sample_count,   exp_count);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_convst(input int budget, output int at);
    bit found = 0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (bus.adc_convst) begin found = 1; at = cyc; break; end
      @(negedge clk);
    end
    chk("wait_convst_bound", found, 1'b1);
  endtask

  task automatic wait_samples(input int n, input int budget);
    logic [15:0] target;
    bit found = 0;
    target = exp_count + 16'(n);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sample_count == target) begin found = 1; break; end
    end
    chk("wait_samples_bound", found, 1'b1);
  endtask

  task automatic load_div(input logic [15:0] v);
    div_value = v;
    div_load  = 1'b1;
    @(negedge clk);
    div_load  = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  int rel0, t, n_tv, n_cs;
  bit found;

  initial begin
    rst = 1'b1; enable = 1'b0; div_load = 1'b0; div_value = '0; clear_flags = 1'b0;
    adc_lat = 5; fir_lat = 20; dac_len = 40; tready_mode = 1'b1; stray = 1'b0;
    fir_word = 32'h0123_0000;
    repeat (3) @(negedge clk);
    chk("rst_dac_value", bus.dac_value, 12'h800);
    chk("rst_convst", bus.adc_convst, 1'b0);

    // First tick after release lands DIV_DEFAULT-1 cycles in; convst follows one cycle later.
    enable = 1'b1;
    rst    = 1'b0;
    rel0   = cyc;
    wait_convst(DIV_DEF + 50, t);
    chk("first_convst_cycle", t - rel0, 10000);
    wait_samples(1, 200);

    // div=100, ADC 5, FIR 20, DAC busy 40: one sample per 100 cycles.
    load_div(16'd100);
    repeat (580) @(negedge clk);
    chk("lit_dac_0123", bus.dac_value, 12'h923);
    chk("lit_count_6", sample_count, 16'd6);
    chk("lit_no_overrun", overrun, 1'b0);
    chk("lit_no_timeout", timeout, 1'b0);

    // Dropping enable lets the current sample finish, then no further ticks occur.
    wait_convst(200, t);
    enable = 1'b0;
    wait_samples(1, 200);
    n_cs = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.adc_convst) n_cs++;
    end
    chk("lit_disabled_convst", n_cs, 0);
    enable = 1'b1;

    // Negative and full-scale FIR results.
    fir_word = 32'hFF00_0000;
    wait_samples(1, 300);
    chk("lit_dac_neg", bus.dac_value, 12'h700);
    fir_word = 32'h07FF_0000;
    wait_samples(1, 300);
    chk("lit_dac_max", bus.dac_value, 12'hFFF);

    // div=50 with a long DAC: every other tick is dropped, and stray pulses are ignored.
    adc_lat = 2; fir_lat = 2; dac_len = 80; stray = 1'b1;
    load_div(16'd50);
    wait_convst(200, t);
    repeat (49) @(negedge clk);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    chk("lit_ovr_set_wins", overrun, 1'b1);
    wait_convst(200, t);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    chk("lit_ovr_cleared", overrun, 1'b0);
    repeat (300) @(negedge clk);
    stray = 1'b0;

    // fir_tready stuck low: the watchdog aborts after TMO cycles.
    dac_len = 40;
    wait_samples(1, 300);
    tready_mode = 1'b0;
    load_div(16'd1500);
    found = 0;
    for (int i = 0; i < 1700; i++) begin
      if (bus.fir_tvalid) begin found = 1; break; end
      @(negedge clk);
    end
    chk("tvalid_bound", found, 1'b1);
    n_tv = 0;
    found = 0;
    for (int i = 0; i < 1100; i++) begin
      if (timeout) begin found = 1; break; end
      if (bus.fir_tvalid) n_tv++;
      @(negedge clk);
    end
    chk("lit_timeout_set", found, 1'b1);
    chk("lit_tvalid_cycles", n_tv, 1023);
    chk("lit_tvalid_dropped", bus.fir_tvalid, 1'b0);
    tready_mode = 1'b1;
    wait_samples(1, 1700);
    chk("lit_timeout_sticky", timeout, 1'b1);

    // Reset mid-sample (in WAIT_FIR), then div_load 0 is clamped to 2.
    fir_lat = 20;
    load_div(16'd100);
    found = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.fir_tvalid && bus.fir_tready) begin found = 1; break; end
      @(negedge clk);
    end
    chk("handshake_bound", found, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("lit_rst_dac", bus.dac_value, 12'h800);
    chk("lit_rst_tdata", bus.fir_tdata, 16'h0000);
    chk("lit_rst_count", sample_count, 16'h0000);
    chk("lit_rst_timeout", timeout, 1'b0);
    chk("lit_rst_tvalid", bus.fir_tvalid, 1'b0);
    load_div(16'd0);
    chk("lit_div2_c1", bus.adc_convst, 1'b0);
    @(negedge clk);
    chk("lit_div2_c2", bus.adc_convst, 1'b0);
    @(negedge clk);
    chk("lit_div2_c3", bus.adc_convst, 1'b1);
    repeat (2) @(negedge clk);
    chk("lit_div2_overrun", overrun, 1'b1);
    repeat (100) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
